// File: rtl/exc_commit.sv
// Writeback commit controller: resolves interrupt / exception / ERET / MTC0 for the WB
// instruction, drives the CP0 strobes and pipeline flush, and holds the fetch redirect.
module exc_commit #(
    parameter logic [31:0] EX_VECTOR = 32'hBFC0_0380,
    parameter logic [4:0]  EXC_INT   = 5'h00,
    parameter int unsigned CR_STATUS = 12,
    parameter int unsigned CR_CAUSE  = 13
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_valid,
    input  logic [31:0] ws_pc,
    input  logic        ws_bd,
    input  logic        ws_ex,
    input  logic [4:0]  ws_excode,
    input  logic [31:0] ws_badvaddr,
    input  logic        ws_eret,
    input  logic        ws_mtc0,
    input  logic [4:0]  ws_c0_addr,
    input  logic [31:0] ws_c0_wdata,
    input  logic        c0_status_ie,
    input  logic        c0_status_exl,
    input  logic [7:0]  c0_status_im,
    input  logic [7:0]  c0_cause_ip,
    input  logic [31:0] c0_epc,
    input  logic        redirect_ready,
    output logic        cp0_ex,
    output logic [4:0]  cp0_excode,
    output logic [31:0] cp0_badvaddr,
    output logic        cp0_bd,
    output logic [31:0] cp0_pc,
    output logic        cp0_mtc0_we,
    output logic [4:0]  cp0_waddr,
    output logic [31:0] cp0_wdata,
    output logic        cp0_eret,
    output logic        flush,
    output logic        ws_allowin,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [4:0] StatusAddr = 5'(CR_STATUS);
    localparam logic [4:0] CauseAddr  = 5'(CR_CAUSE);

    typedef enum logic [0:0] {StIdle, StRedir} state_e;

    state_e      state_q, state_d;
    logic        int_block_q, int_block_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic idle;
    logic commit;
    logic int_pending;
    logic take_int, take_ex, take_eret, take_mtc0;

    assign idle        = (state_q == StIdle);
    assign commit      = idle & ws_valid & resetn;
    assign int_pending = c0_status_ie & ~c0_status_exl & (|(c0_status_im & c0_cause_ip))
                         & ~int_block_q;

    // Fixed priority: interrupt > earlier-stage exception > ERET > MTC0.
    always_comb begin
        take_int  = 1'b0;
        take_ex   = 1'b0;
        take_eret = 1'b0;
        take_mtc0 = 1'b0;
        if (commit) begin
            if (int_pending) begin
                take_int = 1'b1;
            end else if (ws_ex) begin
                take_ex = 1'b1;
            end else if (ws_eret) begin
                take_eret = 1'b1;
            end else if (ws_mtc0) begin
                take_mtc0 = 1'b1;
            end
        end
    end

    assign cp0_ex       = take_int | take_ex;
    assign cp0_excode   = take_int ? EXC_INT : (take_ex ? ws_excode : 5'd0);
    assign cp0_badvaddr = take_ex ? ws_badvaddr : 32'd0;
    assign cp0_bd       = cp0_ex & ws_bd;
    assign cp0_pc       = cp0_ex ? ws_pc : 32'd0;
    assign cp0_eret     = take_eret;
    assign cp0_mtc0_we  = take_mtc0;
    assign cp0_waddr    = take_mtc0 ? ws_c0_addr : 5'd0;
    assign cp0_wdata    = take_mtc0 ? ws_c0_wdata : 32'd0;

    assign flush          = ~idle | cp0_ex | cp0_eret;
    assign ws_allowin     = idle;
    assign redirect_valid = ~idle;
    assign redirect_pc    = idle ? 32'd0 : redirect_pc_q;

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        // Block interrupts for one cycle while CP0 absorbs an ERET or Status/Cause write.
        int_block_d   = take_eret |
                        (take_mtc0 & ((ws_c0_addr == StatusAddr) | (ws_c0_addr == CauseAddr)));
        unique case (state_q)
            StIdle: begin
                if (cp0_ex) begin
                    redirect_pc_d = EX_VECTOR;
                    state_d       = StRedir;
                end else if (cp0_eret) begin
                    redirect_pc_d = c0_epc;
                    state_d       = StRedir;
                end
            end
            StRedir: begin
                if (redirect_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StIdle;
            int_block_q   <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            int_block_q   <= int_block_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

endmodule

// File: tb/tb_exc_commit.sv
// Scoreboard bench for exc_commit: directed scenarios then random traffic, checked against a
// transaction-level model of the commit rules.
module tb_exc_commit;

    logic        clk;
    logic        resetn;
    logic        ws_valid;
    logic [31:0] ws_pc;
    logic        ws_bd;
    logic        ws_ex;
    logic [4:0]  ws_excode;
    logic [31:0] ws_badvaddr;
    logic        ws_eret;
    logic        ws_mtc0;
    logic [4:0]  ws_c0_addr;
    logic [31:0] ws_c0_wdata;
    logic        c0_status_ie;
    logic        c0_status_exl;
    logic [7:0]  c0_status_im;
    logic [7:0]  c0_cause_ip;
    logic [31:0] c0_epc;
    logic        redirect_ready;
    logic        cp0_ex;
    logic [4:0]  cp0_excode;
    logic [31:0] cp0_badvaddr;
    logic        cp0_bd;
    logic [31:0] cp0_pc;
    logic        cp0_mtc0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        cp0_eret;
    logic        flush;
    logic        ws_allowin;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    exc_commit dut (
        .clk           (clk),
        .resetn        (resetn),
        .ws_valid      (ws_valid),
        .ws_pc         (ws_pc),
        .ws_bd         (ws_bd),
        .ws_ex         (ws_ex),
        .ws_excode     (ws_excode),
        .ws_badvaddr   (ws_badvaddr),
        .ws_eret       (ws_eret),
        .ws_mtc0       (ws_mtc0),
        .ws_c0_addr    (ws_c0_addr),
        .ws_c0_wdata   (ws_c0_wdata),
        .c0_status_ie  (c0_status_ie),
        .c0_status_exl (c0_status_exl),
        .c0_status_im  (c0_status_im),
        .c0_cause_ip   (c0_cause_ip),
        .c0_epc        (c0_epc),
        .redirect_ready(redirect_ready),
        .cp0_ex        (cp0_ex),
        .cp0_excode    (cp0_excode),
        .cp0_badvaddr  (cp0_badvaddr),
        .cp0_bd        (cp0_bd),
        .cp0_pc        (cp0_pc),
        .cp0_mtc0_we   (cp0_mtc0_we),
        .cp0_waddr     (cp0_waddr),
        .cp0_wdata     (cp0_wdata),
        .cp0_eret      (cp0_eret),
        .flush         (flush),
        .ws_allowin    (ws_allowin),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    typedef struct {
        logic        resetn;
        logic        valid;
        logic [31:0] pc;
        logic        bd;
        logic        ex;
        logic [4:0]  excode;
        logic [31:0] bad;
        logic        eret;
        logic        mtc0;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        ie;
        logic        exl;
        logic [7:0]  im;
        logic [7:0]  ip;
        logic [31:0] epc;
        logic        rr;
    } stim_t;

    typedef struct {
        logic        ex;
        logic [4:0]  excode;
        logic [31:0] bad;
        logic        bd;
        logic [31:0] pc;
        logic        mwe;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        eret;
        logic        flush;
        logic        allowin;
        logic        rv;
        logic [31:0] rpc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   done    = 0;

    // Model state: whether a redirect is outstanding, its target, and the one-cycle IRQ block.
    bit          m_redir = 0;
    logic [31:0] m_rpc   = '0;
    bit          m_block = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: '0};
        s.resetn = 1'b1;
        return s;
    endfunction

    function automatic exp_t model(stim_t s);
        exp_t e;
        bit   irq;
        bit   nblock;
        e = '{default: '0};
        e.allowin = 1'b1;
        if (!s.resetn) begin
            m_redir = 0;
            m_rpc   = '0;
            m_block = 0;
            return e;
        end
        nblock = 0;
        if (m_redir) begin
            e.allowin = 1'b0;
            e.flush   = 1'b1;
            e.rv      = 1'b1;
            e.rpc     = m_rpc;
            if (s.rr) m_redir = 0;
        end else if (s.valid) begin
            irq = s.ie && !s.exl && ((s.im & s.ip) != 8'h00) && !m_block;
            if (irq || s.ex) begin
                e.ex     = 1'b1;
                e.excode = irq ? 5'h00 : s.excode;
                e.bad    = irq ? 32'h0 : s.bad;
                e.bd     = s.bd;
                e.pc     = s.pc;
                e.flush  = 1'b1;
                m_redir  = 1;
                m_rpc    = 32'hBFC0_0380;
            end else if (s.eret) begin
                e.eret  = 1'b1;
                e.flush = 1'b1;
                m_redir = 1;
                m_rpc   = s.epc;
                nblock  = 1;
            end else if (s.mtc0) begin
                e.mwe   = 1'b1;
                e.waddr = s.addr;
                e.wdata = s.wdata;
                nblock  = (s.addr == 5'd12) || (s.addr == 5'd13);
            end
        end
        m_block = nblock;
        return e;
    endfunction

    task automatic apply(stim_t s);
        @(posedge clk);
        #1;
        resetn         = s.resetn;
        ws_valid       = s.valid;
        ws_pc          = s.pc;
        ws_bd          = s.bd;
        ws_ex          = s.ex;
        ws_excode      = s.excode;
        ws_badvaddr    = s.bad;
        ws_eret        = s.eret;
        ws_mtc0        = s.mtc0;
        ws_c0_addr     = s.addr;
        ws_c0_wdata    = s.wdata;
        c0_status_ie   = s.ie;
        c0_status_exl  = s.exl;
        c0_status_im   = s.im;
        c0_cause_ip    = s.ip;
        c0_epc         = s.epc;
        redirect_ready = s.rr;
        exp_q.push_back(model(s));
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
        end
    endtask

    // Monitor: every cycle the DUT presents a response, compare it with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("cp0_ex",         32'(cp0_ex),         32'(e.ex));
                chk("cp0_excode",     32'(cp0_excode),     32'(e.excode));
                chk("cp0_badvaddr",   cp0_badvaddr,        e.bad);
                chk("cp0_bd",         32'(cp0_bd),         32'(e.bd));
                chk("cp0_pc",         cp0_pc,              e.pc);
                chk("cp0_mtc0_we",    32'(cp0_mtc0_we),    32'(e.mwe));
                chk("cp0_waddr",      32'(cp0_waddr),      32'(e.waddr));
                chk("cp0_wdata",      cp0_wdata,           e.wdata);
                chk("cp0_eret",       32'(cp0_eret),       32'(e.eret));
                chk("flush",          32'(flush),          32'(e.flush));
                chk("ws_allowin",     32'(ws_allowin),     32'(e.allowin));
                chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
                chk("redirect_pc",    redirect_pc,         e.rpc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        resetn = 1'b0;
        {ws_valid, ws_bd, ws_ex, ws_eret, ws_mtc0, c0_status_ie, c0_status_exl} = '0;
        {ws_pc, ws_badvaddr, ws_c0_wdata, c0_epc} = '0;
        {ws_excode, ws_c0_addr} = '0;
        {c0_status_im, c0_cause_ip} = '0;
        redirect_ready = 1'b0;

        s = idle_stim();
        s.resetn = 1'b0;
        apply(s);
        apply(s);

        // Address-error commit in a delay slot, redirect held off for three cycles.
        s = idle_stim();
        s.valid = 1; s.ex = 1; s.excode = 5'h04; s.bad = 32'h0000_1003;
        s.pc = 32'hBFC0_0100; s.bd = 1;
        apply(s);
        s = idle_stim();
        s.valid = 1;
        repeat (3) apply(s);
        s.rr = 1;
        apply(s);
        s.rr = 0;
        apply(s);

        // ERET, then pending interrupt blocked until the redirect retires.
        s = idle_stim();
        s.valid = 1; s.eret = 1; s.epc = 32'hBFC0_1234; s.pc = 32'hBFC0_2000;
        apply(s);
        s = idle_stim();
        s.valid = 1; s.ie = 1; s.im = 8'h80; s.ip = 8'h80; s.rr = 1; s.pc = 32'hBFC0_0040;
        apply(s);
        s.rr = 0;
        apply(s);
        s = idle_stim();
        s.rr = 1;
        apply(s);

        // Interrupt beats an earlier-stage exception.
        s = idle_stim();
        s.valid = 1; s.ex = 1; s.excode = 5'h0C; s.ie = 1; s.im = 8'h04; s.ip = 8'h04;
        s.pc = 32'hBFC0_0200;
        apply(s);
        s = idle_stim();
        s.rr = 1;
        apply(s);

        // MTC0 Status blocks the next-cycle interrupt; MTC0 to reg 11 does not.
        s = idle_stim();
        s.valid = 1; s.mtc0 = 1; s.addr = 5'd12; s.wdata = 32'h0000_8001;
        apply(s);
        s = idle_stim();
        s.valid = 1; s.ie = 1; s.im = 8'h80; s.ip = 8'h80;
        apply(s);
        s = idle_stim();
        s.valid = 1; s.rr = 1;
        apply(s);
        s = idle_stim();
        s.valid = 1; s.mtc0 = 1; s.addr = 5'd11; s.wdata = 32'h1234_5678;
        apply(s);
        s = idle_stim();
        s.valid = 1; s.ie = 1; s.im = 8'h80; s.ip = 8'h80;
        apply(s);

        // Reset dropped in the middle of that redirect.
        s = idle_stim();
        s.resetn = 1'b0;
        apply(s);

        // Masked interrupts: IM/IP disjoint, or EXL set; plus ws_valid=0 with IRQ pending.
        s = idle_stim();
        s.valid = 1; s.ie = 1; s.im = 8'h01; s.ip = 8'h80;
        apply(s);
        s.im = 8'hFF; s.exl = 1;
        apply(s);
        s.exl = 0; s.valid = 0;
        apply(s);
        s = idle_stim();
        s.rr = 1;
        apply(s);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            s = idle_stim();
            s.resetn = ($urandom_range(99) >= 2);
            s.valid  = ($urandom_range(3) != 0);
            s.pc     = $urandom;
            s.bd     = 1'($urandom);
            s.ex     = ($urandom_range(4) == 0);
            s.excode = 5'($urandom);
            s.bad    = $urandom;
            s.eret   = ($urandom_range(6) == 0);
            s.mtc0   = ($urandom_range(3) == 0);
            case ($urandom_range(3))
                0: s.addr = 5'd11;
                1: s.addr = 5'd12;
                2: s.addr = 5'd13;
                default: s.addr = 5'($urandom);
            endcase
            s.wdata  = $urandom;
            s.ie     = ($urandom_range(3) != 0);
            s.exl    = ($urandom_range(3) == 0);
            s.im     = 8'($urandom);
            s.ip     = ($urandom_range(2) == 0) ? 8'($urandom) : 8'h00;
            s.epc    = $urandom;
            s.rr     = 1'($urandom);
            apply(s);
        end

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
